// File: rtl/pixel_adc_readout_pkg.sv
// Shared definitions for the pixel ADC readout block.
// Contents:
//   N_ROWS / N_COLS / CODE_W - pixel array geometry and ADC code width
//   scan_state_e             - readout FSM states
//   row_word_t               - one captured row plus its "first row of frame" tag
//   row_onehot / col_code    - row-enable decode and column extraction helpers
package pixel_pkg;

    localparam int N_ROWS         = 2;
    localparam int N_COLS         = 2;
    localparam int CODE_W         = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int ROW_W          = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int COL_W          = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int WORD_W         = N_COLS * CODE_W;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_SCAN_SEL = 3'd2,
        ST_SCAN_CAP = 3'd3,
        ST_DONE     = 3'd4
    } scan_state_e;

    typedef struct packed {
        logic              first;
        logic [WORD_W-1:0] codes;
    } row_word_t;

    function automatic logic [N_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] row);
        logic [N_ROWS-1:0] v;
        v      = '0;
        v[row] = 1'b1;
        return v;
    endfunction

    function automatic logic [CODE_W-1:0] col_code(input logic [WORD_W-1:0] w,
                                                   input logic [COL_W-1:0]  col);
        return w[col*CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/pixel_adc_readout_if.sv
// Pixel output stream toward the frame buffer (valid/ready).
// Signals:
//   out_valid / out_ready - handshake; a beat moves when both are high
//   out_data              - pixel code
//   out_sof               - first pixel of a frame (row 0, column 0)
//   out_eol               - last pixel of a row
// Modports: master = readout block, slave = frame buffer.
interface pixel_adc_readout_if import pixel_pkg::*; ();

    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;

    modport master (output out_valid, output out_data, output out_sof, output out_eol,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_sof, input  out_eol,
                    output out_ready);

endinterface

// File: rtl/pixel_adc_readout_row_fifo.sv
// Synchronous FIFO of row words between the row scanner and the pixel serializer.
// Ports:
//   clk, reset - clock and asynchronous active-high reset (empties the FIFO)
//   i_push     - write request, i_wdata is the row word
//   i_pop      - remove head entry (ignored when empty)
//   o_rdata    - head entry
//   o_empty    - no entries held
//   o_ovf      - pulse: a push was refused because the FIFO was full
// A push while full is accepted if a pop happens in the same cycle, since the
// pop frees the slot the push needs.
module row_fifo import pixel_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_push,
    input  row_word_t i_wdata,
    input  logic      i_pop,
    output row_word_t o_rdata,
    output logic      o_empty,
    output logic      o_ovf
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    row_word_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    // Accept/refuse decisions for this cycle's push and pop.
    always_comb begin
        w_pop_ok  = i_pop && (r_count != '0);
        w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);
        o_ovf     = i_push && !w_push_ok;
        o_empty   = (r_count == '0);
        o_rdata   = r_mem[r_rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/pixel_adc_readout.sv
// Pixel ADC readout: drives the convert-phase ramp code, scans array rows in
// the read phase into a row FIFO, and serializes pixels onto a stream.
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   convert, read    - phase strobes from the sequencer (edge-detected)
//   ramp_code        - ramp broadcast to pixel comparators
//   row_sel          - one-hot row enable for pixel output drivers
//   pix_row          - selected row's codes, column c at [c*CODE_W +: CODE_W]
//   stream           - pixel stream (master side)
//   err_ovf          - sticky: a row was dropped because the FIFO was full
//   err_trunc        - sticky: read fell before the scan completed
module pixel_adc_readout import pixel_pkg::*; #(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       convert,
    input  logic                       read,
    output logic [CODE_W-1:0]          ramp_code,
    output logic [N_ROWS-1:0]          row_sel,
    input  logic [N_COLS*CODE_W-1:0]   pix_row,
    pixel_adc_readout_if.master        stream,
    output logic                       err_ovf,
    output logic                       err_trunc
);

    scan_state_e       r_state;
    logic [ROW_W-1:0]  r_row;
    logic              r_convert_d;
    logic              r_read_d;
    logic [CODE_W-1:0] r_ramp_code;
    logic [N_ROWS-1:0] r_row_sel;
    logic              r_err_ovf;
    logic              r_err_trunc;
    logic [COL_W-1:0]  r_col;

    logic              w_convert_rise;
    logic              w_read_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_last_col;
    logic              w_fifo_empty;
    logic              w_fifo_ovf;
    row_word_t         w_wdata;
    row_word_t         w_head;

    // Strobe edges, capture request and serializer handshake decode.
    always_comb begin
        w_convert_rise = convert && !r_convert_d;
        w_read_rise    = read && !r_read_d;
        // The row is captured on the SCAN_CAP exit edge unless read has fallen.
        w_push         = (r_state == ST_SCAN_CAP) && read;
        w_wdata        = '{first: (r_row == '0), codes: pix_row};
        w_valid        = !w_fifo_empty;
        w_last_col     = (r_col == COL_W'(N_COLS - 1));
        w_pop          = w_valid && stream.out_ready && w_last_col;
    end

    row_fifo #(.DEPTH(FIFO_DEPTH)) u_row_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_fifo_empty),
        .o_ovf   (w_fifo_ovf)
    );

    // Phase FSM with registered ramp code, row enables and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_convert_d <= 1'b0;
            r_read_d    <= 1'b0;
            r_ramp_code <= '0;
            r_row_sel   <= '0;
            r_err_ovf   <= 1'b0;
            r_err_trunc <= 1'b0;
        end else begin
            r_convert_d <= convert;
            r_read_d    <= read;
            if (w_fifo_ovf) r_err_ovf <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_ramp_code <= '0;
                    r_row_sel   <= '0;
                    // convert has priority when both strobes rise together.
                    if (w_convert_rise) begin
                        r_state <= ST_RAMP;
                    end else if (w_read_rise) begin
                        r_state   <= ST_SCAN_SEL;
                        r_row     <= '0;
                        r_row_sel <= row_onehot('0);
                    end
                end
                ST_RAMP: begin
                    if (convert) begin
                        if (r_ramp_code != '1) r_ramp_code <= r_ramp_code + CODE_W'(1);
                    end else begin
                        r_state     <= ST_IDLE;
                        r_ramp_code <= '0;
                    end
                end
                ST_SCAN_SEL: begin
                    if (!read) begin
                        r_state     <= ST_IDLE;
                        r_row_sel   <= '0;
                        r_err_trunc <= 1'b1;
                    end else begin
                        r_state <= ST_SCAN_CAP;
                    end
                end
                ST_SCAN_CAP: begin
                    if (!read) begin
                        r_state     <= ST_IDLE;
                        r_row_sel   <= '0;
                        r_err_trunc <= 1'b1;
                    end else if (r_row == ROW_W'(N_ROWS - 1)) begin
                        r_state   <= ST_DONE;
                        r_row_sel <= '0;
                    end else begin
                        r_state   <= ST_SCAN_SEL;
                        r_row     <= r_row + ROW_W'(1);
                        r_row_sel <= row_onehot(r_row + ROW_W'(1));
                    end
                end
                ST_DONE: begin
                    r_row_sel <= '0;
                    if (!read) r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ramp_code <= '0;
                    r_row_sel   <= '0;
                end
            endcase
        end
    end

    // Serializer column index; advances on each accepted beat of the head row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else if (w_valid && stream.out_ready) begin
            r_col <= w_last_col ? '0 : r_col + COL_W'(1);
        end
    end

    // Stream outputs are pure functions of FIFO head and column, so they hold while stalled.
    always_comb begin
        stream.out_valid = w_valid;
        if (w_valid) begin
            stream.out_data = col_code(w_head.codes, r_col);
            stream.out_sof  = w_head.first && (r_col == '0);
            stream.out_eol  = w_last_col;
        end else begin
            stream.out_data = '0;
            stream.out_sof  = 1'b0;
            stream.out_eol  = 1'b0;
        end
        ramp_code = r_ramp_code;
        row_sel   = r_row_sel;
        err_ovf   = r_err_ovf;
        err_trunc = r_err_trunc;
    end

endmodule
